// File: rtl/mlu_pkg.sv
// mlu_pkg: shared helpers for mlu_pipe: parameter legality checks, product width and
// the split of partial-product reduction levels across the pipeline stages.
package mlu_pkg;

   function automatic int prod_width(input int width);
      return 32'sd2 * width;
   endfunction

   function automatic bit width_legal(input int width);
      return (width >= 32'sd8) && (width <= 32'sd64) && ((width % 32'sd2) == 32'sd0);
   endfunction

   function automatic bit stages_legal(input int stages);
      return (stages >= 32'sd1) && (stages <= 32'sd4);
   endfunction

   // One partial-product row per multiplier bit, including the extension bit.
   function automatic int pp_rows(input int width);
      return width + 32'sd1;
   endfunction

   function automatic int tree_levels(input int rows);
      return $clog2(rows);
   endfunction

   function automatic int rows_at_level(input int rows, input int lvl);
      int r;
      r = rows;
      for (int i = 0; i < lvl; i++) begin
         r = (r + 32'sd1) / 32'sd2;
      end
      return r;
   endfunction

   // Stage 1 only captures operands unless it is the sole stage; the tree is spread
   // as evenly as possible over stages 2..stages.
   function automatic int levels_in_stage(input int stage, input int lv, input int stages);
      if (stages == 32'sd1) begin
         return (stage == 32'sd1) ? lv : 32'sd0;
      end else if ((stage < 32'sd2) || (stage > stages)) begin
         return 32'sd0;
      end else begin
         return (((stage - 32'sd1) * lv) / (stages - 32'sd1)) -
                (((stage - 32'sd2) * lv) / (stages - 32'sd1));
      end
   endfunction

   function automatic int level_end(input int stage, input int lv, input int stages);
      int acc;
      acc = 32'sd0;
      for (int s = 1; s <= stage; s++) begin
         acc = acc + levels_in_stage(s, lv, stages);
      end
      return acc;
   endfunction

   // True when an intermediate pipeline register follows tree level lvl.
   function automatic bit reg_after_level(input int lvl, input int lv, input int stages);
      for (int s = 2; s < stages; s++) begin
         if (level_end(s, lv, stages) == lvl) begin
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

endpackage

// File: rtl/mlu_pp_reduce.sv
// mlu_pp_reduce: one adder level of the partial-product tree. Adjacent rows are paired,
// the odd row weighted by 2**SHIFT; an unpaired last row passes through unchanged.
module mlu_pp_reduce #(
   parameter int N_IN  = 2,
   parameter int W     = 16,
   parameter int SHIFT = 1
) (
   input  logic [N_IN*W-1:0]         rows_in,
   output logic [((N_IN+1)/2)*W-1:0] rows_out
);

   localparam int N_OUT = (N_IN + 1) / 2;

   for (genvar k = 0; k < N_OUT; k++) begin : g_pair
      if (2 * k + 1 < N_IN) begin : g_add
         assign rows_out[k*W +: W] = rows_in[2*k*W +: W] + (rows_in[(2*k+1)*W +: W] << SHIFT);
      end else begin : g_pass
         assign rows_out[k*W +: W] = rows_in[2*k*W +: W];
      end
   end

endmodule

// File: rtl/mlu_pipe.sv
// mlu_pipe: pipelined WIDTH x WIDTH multiplier with per-operand signedness, tag passthrough
// and flush. Signed operands are honoured only when MLU_SIGNED_EN is defined.
module mlu_pipe
   import mlu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 3,
   parameter int TAG_W  = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_op1,
   input  logic [WIDTH-1:0]   in_op2,
   input  logic               in_op1_signed,
   input  logic               in_op2_signed,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_result,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int PW = prod_width(WIDTH);
   localparam int NR = pp_rows(WIDTH);
   localparam int LV = tree_levels(NR);

   if (!width_legal(WIDTH)) begin : g_bad_width
      $error("mlu_pipe: WIDTH must be even and within 8..64");
   end
   if (!stages_legal(STAGES)) begin : g_bad_stages
      $error("mlu_pipe: STAGES must be within 1..4");
   end

   logic              en_s;
   logic [WIDTH:0]    op1_ext_s;
   logic [WIDTH:0]    op2_ext_s;
   logic [WIDTH:0]    pp_a_s;
   logic [WIDTH:0]    pp_b_s;
   logic [PW-1:0]     a_pos_s;
   logic [PW-1:0]     a_neg_s;
   logic [STAGES-1:0] vld_r;
   logic [TAG_W-1:0]  tag_r [STAGES];
   logic [PW-1:0]     result_r;

   assign en_s       = ~(vld_r[STAGES-1] & ~out_ready) & ~flush;
   assign in_ready   = en_s;
   assign out_valid  = vld_r[STAGES-1];
   assign out_result = result_r;
   assign out_tag    = tag_r[STAGES-1];

`ifdef MLU_SIGNED_EN
   assign op1_ext_s = {in_op1_signed & in_op1[WIDTH-1], in_op1};
   assign op2_ext_s = {in_op2_signed & in_op2[WIDTH-1], in_op2};
`else
   logic unused_sign_flags_s;
   assign unused_sign_flags_s = in_op1_signed ^ in_op2_signed;
   assign op1_ext_s = {1'b0, in_op1};
   assign op2_ext_s = {1'b0, in_op2};
`endif

   if (STAGES > 1) begin : g_op_reg
      logic [WIDTH:0] a_r;
      logic [WIDTH:0] b_r;
      // Stage 1 captures the extended operands.
      always_ff @(posedge clk) begin
         if (en_s) begin
            a_r <= op1_ext_s;
            b_r <= op2_ext_s;
         end
      end
      assign pp_a_s = a_r;
      assign pp_b_s = b_r;
   end else begin : g_op_comb
      assign pp_a_s = op1_ext_s;
      assign pp_b_s = op2_ext_s;
   end

   // The extension bit of op2 carries weight -2**WIDTH, hence the negated top row.
   assign a_pos_s = {{(PW-WIDTH-1){pp_a_s[WIDTH]}}, pp_a_s};
   assign a_neg_s = {PW{1'b0}} - a_pos_s;

   for (genvar l = 0; l <= LV; l++) begin : g_lvl
      localparam int NO = rows_at_level(NR, l);
      logic [NO*PW-1:0] d_s;
      logic [NO*PW-1:0] q_s;
      if (l == 0) begin : g_pp
         for (genvar i = 0; i < NR; i++) begin : g_row
            if (i < WIDTH) begin : g_plain
               assign d_s[i*PW +: PW] = pp_b_s[i] ? a_pos_s : {PW{1'b0}};
            end else begin : g_sign
               assign d_s[i*PW +: PW] = pp_b_s[i] ? a_neg_s : {PW{1'b0}};
            end
         end
      end else begin : g_add
         mlu_pp_reduce #(
            .N_IN (rows_at_level(NR, l - 1)),
            .W    (PW),
            .SHIFT(1 << (l - 1))
         ) u_reduce (
            .rows_in (g_lvl[l-1].q_s),
            .rows_out(d_s)
         );
      end
      if (reg_after_level(l, LV, STAGES)) begin : g_reg
         logic [NO*PW-1:0] r_r;
         // Intermediate stage boundary inside the reduction tree.
         always_ff @(posedge clk) begin
            if (en_s) begin
               r_r <= d_s;
            end
         end
         assign q_s = r_r;
      end else begin : g_wire
         assign q_s = d_s;
      end
   end

   // Stage valid bits and tags: flush wins over any advance, bubbles are kept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_r <= {STAGES{1'b0}};
         for (int s = 0; s < STAGES; s++) begin
            tag_r[s] <= {TAG_W{1'b0}};
         end
      end else if (flush) begin
         vld_r <= {STAGES{1'b0}};
      end else if (en_s) begin
         vld_r[0] <= in_valid;
         tag_r[0] <= in_tag;
         for (int s = 1; s < STAGES; s++) begin
            vld_r[s] <= vld_r[s-1];
            tag_r[s] <= tag_r[s-1];
         end
      end
   end

   // Final stage holds the completed product.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_r <= {PW{1'b0}};
      end else if (en_s) begin
         result_r <= g_lvl[LV].q_s;
      end
   end

endmodule
